thor2025_freelist: RTL and testbench
====================================

THOR2025_FREELIST -- requirements
Module: Thor2025_freelist

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning:
- NPREG, 96, number of physical registers.
- NARCH, 32, physical registers 0..NARCH-1 mapped to architectural registers at reset.
- NFREE, 4, free ports per cycle.

REQ-002 Ports SHALL be one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- alloc_n, in, 2, number of target tags the rename stage consumes this cycle (0..3).
- alloc_ack, out, 1, allocation accepted this cycle.
- alloc_tag0, out, 7, first free physical register offered.
- alloc_tag1, out, 7, second free physical register offered.
- alloc_tag2, out, 7, third free physical register offered.
- free_v, in, NFREE, per-port free strobe.
- free_tag, in, 7 x NFREE, tags returned at commit (previous mapping) or on branch-miss squash.
- free_cnt, out, 7, number of free registers.
- double_free, out, 1, registered error pulse.

REQ-003 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk.

Function
REQ-004 State SHALL be a registered NPREG-bit free bitmap (1 = free) plus a registered 7-bit free_cnt that always equals the bitmap popcount.

REQ-005 alloc_tag0/1/2 SHALL be combinational from the current bitmap: the lowest, second-lowest and third-lowest set bit indices. Any slot with no candidate SHALL read 0.

REQ-006 alloc_ack SHALL be (alloc_n != 0) and (free_cnt >= 3). It is combinational and needs no request/grant round trip.

REQ-007 When alloc_ack=1, the first alloc_n offered tags SHALL be cleared in the bitmap at the next rising edge. Unconsumed offered tags SHALL remain free.

REQ-008 When alloc_ack=0, the bitmap SHALL not change due to allocation. The rename stage stalls and holds alloc_n.

REQ-009 Each free port with free_v=1 and free_tag in 1..NPREG-1 SHALL set that bitmap bit at the next edge.

REQ-010 Tag 0 SHALL never be offered, allocated or freed. A free of tag 0 is silently ignored. Tags >= NPREG are ignored.

REQ-011 Duplicate tags across free ports in one cycle SHALL be counted once and SHALL NOT raise double_free.

REQ-012 Freeing a tag whose bit is already 1 (and which is not being allocated the same cycle) SHALL leave the bit at 1, add nothing to free_cnt, and assert double_free for exactly one cycle following.

REQ-013 Next free_cnt SHALL equal free_cnt - (alloc_ack ? alloc_n : 0) + the number of unique newly-set bits. Arithmetic is 7-bit and SHALL never wrap; free_cnt <= NPREG-1 by construction.

REQ-014 A tag freed in cycle N SHALL become visible on alloc_tag* no earlier than cycle N+1. There is no same-cycle bypass.

REQ-015 If a tag is simultaneously allocated and freed in one cycle, free SHALL win: the bit ends at 1, the net count change is 0, and double_free is asserted.

REQ-016 Allocation and freeing SHALL be fully concurrent with no ordering dependency between ports.

Reset
REQ-017 On rst:
- bitmap bits 0..NARCH-1 = 0 and bits NARCH..NPREG-1 = 1;
- free_cnt = NPREG-NARCH (64);
- double_free = 0.
As a result, alloc_tag0/1/2 = 32/33/34 in the cycle after reset.

REQ-018 rst SHALL override all same-cycle allocation and free activity. Reset mid-operation discards all pending state.

Verification
REQ-019 Reset, then alloc_n=0 -> alloc_tag0/1/2 = 32/33/34, free_cnt=64, alloc_ack=0, double_free=0.

REQ-020 alloc_n=3 for one cycle -> alloc_ack=1; next cycle tags = 35/36/37 and free_cnt=61. Then alloc_n=1 -> next cycle tags = 36/37/38 and free_cnt=60.

REQ-021 Allocate until free_cnt=2 -> alloc_ack=0 with alloc_n=3, and bitmap/free_cnt hold. Then free tag 40 -> next cycle free_cnt=3 and alloc_ack=1.

REQ-022 With free_cnt=10, apply the following in one cycle -> next cycle free_cnt=10, double_free=0, and alloc_tag0=33 (tag 32 allocated, 33 freed):
- alloc_n=1 taking tag 32;
- free_v=4'b0111 with tags 33, 33, 0 (33 previously allocated).

REQ-023 Free tag 50 while it is already free -> free_cnt unchanged and double_free=1 for exactly one cycle.

REQ-024 Assert rst mid-stream after 20 allocations and 5 frees -> next cycle free_cnt=64, tags 32/33/34, double_free=0.

Source files
------------

// File: rtl/thor2025_freelist.sv
// Physical-register free list: a bitmap of free tags with a shadow popcount.
// It offers the three lowest free tags each cycle and takes back up to NFREE tags per cycle.
module thor2025_freelist #(
    parameter int NPREG = 96,
    parameter int NARCH = 32,
    parameter int NFREE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            alloc_n,
    output logic                  alloc_ack,
    output logic [6:0]            alloc_tag0,
    output logic [6:0]            alloc_tag1,
    output logic [6:0]            alloc_tag2,
    input  logic [NFREE-1:0]      free_v,
    input  logic [NFREE-1:0][6:0] free_tag,
    output logic [6:0]            free_cnt,
    output logic                  double_free
);

    function automatic logic [NPREG-1:0] reset_map();
        logic [NPREG-1:0] m;
        for (int i = 0; i < NPREG; i++) m[i] = (i >= NARCH);
        return m;
    endfunction

    function automatic logic [6:0] popcount(input logic [NPREG-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < NPREG; i++) c = c + 7'(v[i]);
        return c;
    endfunction

    localparam logic [NPREG-1:0] RST_MAP = reset_map();

    logic [NPREG-1:0] free_q, free_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             dfree_q, dfree_d;

    logic [NPREG-1:0] alloc_mask, free_mask;
    logic [1:0]       found;

    // Priority pick of the three lowest free tags; bit 0 is never a candidate.
    always_comb begin
        alloc_tag0 = '0;
        alloc_tag1 = '0;
        alloc_tag2 = '0;
        found      = '0;
        for (int i = 1; i < NPREG; i++) begin
            if (free_q[i] && found != 2'd3) begin
                case (found)
                    2'd0:    alloc_tag0 = 7'(i);
                    2'd1:    alloc_tag1 = 7'(i);
                    default: alloc_tag2 = 7'(i);
                endcase
                found = found + 2'd1;
            end
        end
    end

    assign alloc_ack = (alloc_n != 2'd0) && (cnt_q >= 7'd3);

    always_comb begin
        alloc_mask = '0;
        if (alloc_ack) begin
            alloc_mask[alloc_tag0] = 1'b1;
            if (alloc_n >= 2'd2) alloc_mask[alloc_tag1] = 1'b1;
            if (alloc_n == 2'd3) alloc_mask[alloc_tag2] = 1'b1;
        end
    end

    // Duplicate tags across ports collapse naturally into one mask bit.
    always_comb begin
        free_mask = '0;
        for (int p = 0; p < NFREE; p++) begin
            if (free_v[p] && free_tag[p] != 7'd0 && 32'(free_tag[p]) < NPREG)
                free_mask[free_tag[p]] = 1'b1;
        end
    end

    // Free wins over a same-cycle allocation of the same tag; the count is
    // derived from the next bitmap so it can never drift from it.
    always_comb begin
        free_d    = (free_q & ~alloc_mask) | free_mask;
        free_d[0] = 1'b0;
        cnt_d     = popcount(free_d);
        dfree_d   = |(free_mask & free_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q  <= RST_MAP;
            cnt_q   <= 7'(NPREG - NARCH);
            dfree_q <= 1'b0;
        end else begin
            free_q  <= free_d;
            cnt_q   <= cnt_d;
            dfree_q <= dfree_d;
        end
    end

    assign free_cnt    = cnt_q;
    assign double_free = dfree_q;

endmodule

// File: tb/tb_thor2025_freelist.sv
// Directed bench for thor2025_freelist: expected outputs are queued per cycle
// and compared by a separate negedge monitor.
module tb_thor2025_freelist;

    logic             clk;
    logic             rst;
    logic [1:0]       alloc_n;
    logic             alloc_ack;
    logic [6:0]       alloc_tag0, alloc_tag1, alloc_tag2;
    logic [3:0]       free_v;
    logic [3:0][6:0]  free_tag;
    logic [6:0]       free_cnt;
    logic             double_free;

    thor2025_freelist #(.NPREG(96), .NARCH(32), .NFREE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_n     (alloc_n),
        .alloc_ack   (alloc_ack),
        .alloc_tag0  (alloc_tag0),
        .alloc_tag1  (alloc_tag1),
        .alloc_tag2  (alloc_tag2),
        .free_v      (free_v),
        .free_tag    (free_tag),
        .free_cnt    (free_cnt),
        .double_free (double_free)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // scoreboard: {ack, df, cnt[6:0], tag0, tag1, tag2}
    logic [29:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [29:0] e, a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {alloc_ack, double_free, free_cnt, alloc_tag0, alloc_tag1, alloc_tag2};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s got ack=%0b df=%0b cnt=%0d tags=%0d/%0d/%0d exp ack=%0b df=%0b cnt=%0d tags=%0d/%0d/%0d",
                         nm, a[29], a[28], a[27:21], a[20:14], a[13:7], a[6:0],
                         e[29], e[28], e[27:21], e[20:14], e[13:7], e[6:0]);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] an, input logic [3:0] fv,
                         input logic [6:0] t0, input logic [6:0] t1,
                         input logic [6:0] t2, input logic [6:0] t3);
        alloc_n     = an;
        free_v      = fv;
        free_tag[0] = t0;
        free_tag[1] = t1;
        free_tag[2] = t2;
        free_tag[3] = t3;
    endtask

    task automatic expect_out(input string nm, input logic ack, input logic df,
                              input int cnt, input int t0, input int t1, input int t2);
        exp_q.push_back({ack, df, 7'(cnt), 7'(t0), 7'(t1), 7'(t2)});
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc_cycles(input int n, input logic [1:0] an);
        for (int i = 0; i < n; i++) begin
            drive(an, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        do_reset();

        // reset state and basic allocation
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("reset_state", 1'b0, 1'b0, 64, 32, 33, 34); tick();
        drive(2'd3, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("alloc3_ack", 1'b1, 1'b0, 64, 32, 33, 34); tick();
        drive(2'd1, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("after_alloc3", 1'b1, 1'b0, 61, 35, 36, 37); tick();
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("after_alloc1", 1'b0, 1'b0, 60, 36, 37, 38); tick();

        // drain toward the low-water mark
        for (int k = 0; k < 19; k++) begin
            drive(2'd3, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
            expect_out("drain", 1'b1, 1'b0, 60 - 3 * k, 36 + 3 * k, 37 + 3 * k, 38 + 3 * k);
            tick();
        end
        drive(2'd1, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("cnt3_ack", 1'b1, 1'b0, 3, 93, 94, 95); tick();
        drive(2'd3, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("cnt2_stall", 1'b0, 1'b0, 2, 94, 95, 0); tick();
        drive(2'd3, 4'b0001, 7'd40, 7'd0, 7'd0, 7'd0);
        expect_out("stall_hold_free40", 1'b0, 1'b0, 2, 94, 95, 0); tick();
        drive(2'd3, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("free40_visible", 1'b1, 1'b0, 3, 40, 94, 95); tick();
        drive(2'd1, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("empty_no_ack", 1'b0, 1'b0, 0, 0, 0, 0); tick();
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("empty_hold", 1'b0, 1'b0, 0, 0, 0, 0); tick();

        // concurrent alloc/free with duplicate and tag-0 ports
        do_reset();
        alloc_cycles(18, 2'd3);
        drive(2'd1, 4'b0001, 7'd32, 7'd0, 7'd0, 7'd0);
        expect_out("setup_alloc86", 1'b1, 1'b0, 10, 86, 87, 88); tick();
        drive(2'd1, 4'b0111, 7'd33, 7'd33, 7'd0, 7'd0);
        expect_out("cnt10_concurrent", 1'b1, 1'b0, 10, 32, 87, 88); tick();
        drive(2'd0, 4'b0001, 7'd50, 7'd0, 7'd0, 7'd0);
        expect_out("after_concurrent", 1'b0, 1'b0, 10, 33, 87, 88); tick();

        // double free of an already-free tag
        drive(2'd0, 4'b0001, 7'd50, 7'd0, 7'd0, 7'd0);
        expect_out("free50_first", 1'b0, 1'b0, 11, 33, 50, 87); tick();
        drive(2'd1, 4'b0001, 7'd33, 7'd0, 7'd0, 7'd0);
        expect_out("double_free50", 1'b1, 1'b1, 11, 33, 50, 87); tick();
        // alloc and free of tag 33 in the same cycle: free wins
        drive(2'd0, 4'b0011, 7'd100, 7'd0, 7'd0, 7'd0);
        expect_out("alloc_free_same_tag", 1'b0, 1'b1, 11, 33, 50, 87); tick();
        drive(2'd0, 4'b1111, 7'd60, 7'd61, 7'd62, 7'd63);
        expect_out("ignored_tags", 1'b0, 1'b0, 11, 33, 50, 87); tick();
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("four_frees", 1'b0, 1'b0, 15, 33, 50, 60); tick();

        // reset mid-stream after 20 allocations and 5 frees
        do_reset();
        alloc_cycles(6, 2'd3);
        alloc_cycles(1, 2'd2);
        drive(2'd0, 4'b0111, 7'd32, 7'd33, 7'd34, 7'd0); tick();
        drive(2'd0, 4'b0011, 7'd35, 7'd36, 7'd0, 7'd0); tick();
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("pre_reset", 1'b0, 1'b0, 49, 32, 33, 34); tick();
        rst = 1'b1;
        drive(2'd3, 4'b0001, 7'd32, 7'd0, 7'd0, 7'd0);
        tick();
        rst = 1'b0;
        drive(2'd0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
        expect_out("mid_reset", 1'b0, 1'b0, 64, 32, 33, 34); tick();
        expect_out("mid_reset_hold", 1'b0, 1'b0, 64, 32, 33, 34); tick();

        // final report
        tick();
        tick();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
